// File: rtl/hdp_sram_pkg.sv
// Shared constants and transaction types for the 32x2048 SRAM port-0 front-end.
package hdp_sram_pkg;

  localparam int SRAM_ADDR_W = 11;
  localparam int SRAM_DATA_W = 32;
  localparam int SRAM_NMASK  = 4;

  localparam logic CSB_IDLE = 1'b1;
  localparam logic WEB_IDLE = 1'b1;

  typedef struct packed {
    logic                   we;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
    logic [SRAM_NMASK-1:0]  wstrb;
  } sram_req_t;

  typedef struct packed {
    logic [SRAM_DATA_W-1:0] rdata;
    logic                   err;
  } sram_rsp_t;

endpackage

// File: rtl/hdp_pipe_stage.sv
// Single valid/ready register slice; the payload is loaded only when a beat is accepted.
module hdp_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/hdp_sram_port0_ctrl.sv
// Port-0 front-end of the 32x2048 SRAM macro: registered one-cycle strobe stage (S1)
// followed by a response register slice (S2), two cycles from accept to response.
module hdp_sram_port0_ctrl
  import hdp_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_W,
  parameter int DATA_WIDTH = SRAM_DATA_W,
  parameter int NUM_WMASKS = SRAM_NMASK
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_WMASKS-1:0] req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  sram_req_t req_c;
  sram_rsp_t rsp_p1, rsp_p2;
  logic      misaligned;
  logic      vld_p1, we_p1, err_p1;
  logic      rdy_p2;
  logic      req_fire;

  assign req_c.we    = req_we;
  assign req_c.addr  = req_addr[ADDR_WIDTH+1:2];
  assign req_c.wdata = req_wdata;
  assign req_c.wstrb = req_wstrb;
  assign misaligned  = |req_addr[1:0];

  assign req_ready = !rst && (!vld_p1 || rdy_p2);
  assign req_fire  = req_valid && req_ready;

  // Stage S1: strobe registers drive the macro for exactly one cycle per accepted request
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      we_p1       <= 1'b0;
      err_p1      <= 1'b0;
      sram_csb0   <= CSB_IDLE;
      sram_web0   <= WEB_IDLE;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
    end else if (req_fire) begin
      vld_p1      <= 1'b1;
      we_p1       <= req_c.we;
      err_p1      <= misaligned;
      sram_csb0   <= misaligned ? CSB_IDLE : 1'b0;
      sram_web0   <= (misaligned || !req_c.we) ? WEB_IDLE : 1'b0;
      sram_wmask0 <= (req_c.we && !misaligned) ? req_c.wstrb : '0;
      sram_addr0  <= req_c.addr;
      sram_din0   <= req_c.wdata;
    end else begin
      if (rdy_p2) vld_p1 <= 1'b0;
      sram_csb0   <= CSB_IDLE;
      sram_web0   <= WEB_IDLE;
      sram_wmask0 <= '0;
    end
  end

  // dout0 stays stable through an S1 stall since no other port-0 read is issued meanwhile
  assign rsp_p1.rdata = (we_p1 || err_p1) ? '0 : sram_dout0;
  assign rsp_p1.err   = err_p1;

  // Stage S2: response register
  hdp_pipe_stage #(
    .W($bits(sram_rsp_t))
  ) u_rsp_p2 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (vld_p1),
    .in_ready (rdy_p2),
    .in_data  (rsp_p1),
    .out_valid(rsp_valid),
    .out_ready(rsp_ready),
    .out_data (rsp_p2)
  );

  assign rsp_rdata = rsp_p2.rdata;
  assign rsp_err   = rsp_p2.err;

endmodule

// File: tb/tb_hdp_sram_port0_ctrl.sv
// Directed bench for hdp_sram_port0_ctrl with a behavioural 32x2048 macro on port 0.
module tb_hdp_sram_port0_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [12:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        sram_csb0, sram_web0;
  logic [3:0]  sram_wmask0;
  logic [10:0] sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0;

  int tests = 0;
  int fails = 0;
  int strobe_cnt = 0;

  logic [31:0] mem [0:2047];

  always #5 clk = ~clk;

  hdp_sram_port0_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .sram_csb0  (sram_csb0),
    .sram_web0  (sram_web0),
    .sram_wmask0(sram_wmask0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_dout0 (sram_dout0)
  );

  // Macro model: acts on the negedge inside the strobe cycle, dout holds between reads
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    sram_dout0 = 32'h0;
  end

  always @(negedge clk) begin
    if (!sram_csb0) begin
      strobe_cnt <= strobe_cnt + 1;
      if (!sram_web0) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask0[b]) mem[sram_addr0][b*8 +: 8] <= sram_din0[b*8 +: 8];
      end else begin
        sram_dout0 <= mem[sram_addr0];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_txn(input logic we, input logic [12:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, output logic [31:0] rd, output logic er,
                        output int lat, output int strobes);
    int s0;
    int k;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_wstrb = ws;
    rd  = 32'hxxxxxxxx;
    er  = 1'bx;
    lat = -1;
    k   = 0;
    @(negedge clk);
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    s0 = strobe_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = c;
        rd  = rsp_rdata;
        er  = rsp_err;
        break;
      end
    end
    @(posedge clk);
    #1 strobes = strobe_cnt - s0;
  endtask

  typedef struct {
    logic        we;
    logic [12:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_strobes;
  } vec_t;

  task automatic run_table();
    vec_t v [12];
    logic [31:0] rd;
    logic        er;
    int          lat, st;
    v[0]  = '{1'b1, 13'h010,  32'hDEADBEEF, 4'hF, 1'b0, 32'h0,        1};
    v[1]  = '{1'b0, 13'h010,  32'h0,        4'h0, 1'b0, 32'hDEADBEEF, 1};
    v[2]  = '{1'b1, 13'h010,  32'h11223344, 4'h2, 1'b0, 32'h0,        1};
    v[3]  = '{1'b0, 13'h010,  32'h0,        4'h0, 1'b0, 32'hDEAD33EF, 1};
    v[4]  = '{1'b0, 13'h013,  32'h0,        4'h0, 1'b1, 32'h0,        0};
    v[5]  = '{1'b1, 13'h010,  32'hFFFFFFFF, 4'h0, 1'b0, 32'h0,        1};
    v[6]  = '{1'b0, 13'h010,  32'h0,        4'h0, 1'b0, 32'hDEAD33EF, 1};
    v[7]  = '{1'b1, 13'h012,  32'h01020304, 4'hF, 1'b1, 32'h0,        0};
    v[8]  = '{1'b0, 13'h010,  32'h0,        4'h0, 1'b0, 32'hDEAD33EF, 1};
    v[9]  = '{1'b1, 13'h1FFC, 32'h87654321, 4'h9, 1'b0, 32'h0,        1};
    v[10] = '{1'b0, 13'h1FFC, 32'h0,        4'h0, 1'b0, 32'h87000021, 1};
    v[11] = '{1'b0, 13'h000,  32'h0,        4'h0, 1'b0, 32'h0,        1};
    for (int i = 0; i < 12; i++) begin
      do_txn(v[i].we, v[i].addr, v[i].wdata, v[i].wstrb, rd, er, lat, st);
      chk($sformatf("vec%0d latency", i), lat, 2);
      chk($sformatf("vec%0d err", i), {31'b0, er}, {31'b0, v[i].exp_err});
      chk($sformatf("vec%0d rdata", i), rd, v[i].exp_rdata);
      chk($sformatf("vec%0d strobes", i), st, v[i].exp_strobes);
    end
  endtask

  task automatic run_stream();
    logic [31:0] got [$];
    logic [31:0] rd, act;
    logic        er;
    int          lat, st, s0;
    logic        saw_block;
    for (int i = 0; i < 8; i++) begin
      do_txn(1'b1, 13'(i * 4), 32'hC0DE0000 | i, 4'hF, rd, er, lat, st);
      chk($sformatf("prewrite%0d latency", i), lat, 2);
      chk($sformatf("prewrite%0d err", i), {31'b0, er}, 32'h0);
    end
    saw_block = 1'b0;
    s0 = strobe_cnt;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          int w;
          w = 0;
          req_valid = 1'b1;
          req_we    = 1'b0;
          req_addr  = 13'(i * 4);
          @(negedge clk);
          while (!req_ready && w < 50) begin
            saw_block = 1'b1;
            @(negedge clk);
            w++;
          end
          @(posedge clk);
          #1;
        end
        req_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 40; c++) begin
          rsp_ready = !(c >= 3 && c <= 6);
          @(negedge clk);
          if (rsp_valid && rsp_ready) got.push_back(rsp_rdata);
          @(posedge clk);
          #1;
        end
        rsp_ready = 1'b1;
      end
    join
    chk("stream rsp count", got.size(), 8);
    for (int i = 0; i < 8; i++) begin
      act = (i < got.size()) ? got[i] : 32'hxxxxxxxx;
      chk($sformatf("stream rsp%0d", i), act, 32'hC0DE0000 | i);
    end
    chk("stream strobes", strobe_cnt - s0, 8);
    chk("stream req_ready drop", {31'b0, saw_block}, 32'h1);
  endtask

  task automatic run_reset_mid();
    logic [31:0] rd;
    logic        er;
    int          lat, st, s0, seen;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 13'h014;
    req_wdata = 32'h5A5A5A5A;
    req_wstrb = 4'hF;
    @(negedge clk);
    s0 = strobe_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("rst-mid strobes", strobe_cnt - s0, 1);
    chk("rst-mid rsp dropped", seen, 0);
    @(posedge clk);
    #1;
    do_txn(1'b0, 13'h014, 32'h0, 4'h0, rd, er, lat, st);
    chk("rst-mid readback latency", lat, 2);
    chk("rst-mid readback err", {31'b0, er}, 32'h0);
    chk("rst-mid readback rdata", rd, 32'h5A5A5A5A);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset csb0", {31'b0, sram_csb0}, 32'h1);
    chk("reset web0", {31'b0, sram_web0}, 32'h1);
    chk("reset wmask0", {28'b0, sram_wmask0}, 32'h0);
    chk("reset rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("reset req_ready", {31'b0, req_ready}, 32'h0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("release req_ready", {31'b0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    run_table();
    run_stream();
    run_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
